// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN parameter loader: chain sizing helpers,
// loader FSM states and the CRC-8 polynomial used for chain readback.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ld_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
    return neurons * (inputs + bias_bits);
  endfunction

  function automatic int chain_words(input int bits, input int word_bits);
    return (bits + word_bits - 1) / word_bits;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0x00) over the bits returned from the
// neuron chain tail.
module crc8_serial
  import bnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (enable) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/param_loader.sv
// Serialises host parameter words MSB-first into the neuron setup chain.
// Optional chain readback CRC is built when PARAM_READBACK_EN is defined.
module param_loader
  import bnn_pkg::*;
#(
  parameter int NEURONS   = 8,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 setup,
  output logic                 param_out,
  input  logic                 chain_in,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           readback_crc
);

  localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
  localparam int WORDS      = chain_words(CHAIN_BITS, WORD_BITS);
  localparam int BCNT_W     = $clog2(CHAIN_BITS + 1);
  localparam int WCNT_W     = $clog2(WORDS + 1);
  localparam int LEFT_W     = $clog2(WORD_BITS + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(CHAIN_BITS - 1);
  localparam logic [WCNT_W-1:0] WORDS_C  = WCNT_W'(WORDS);
  localparam logic [LEFT_W-1:0] WORD_C   = LEFT_W'(WORD_BITS);
  localparam logic [LEFT_W-1:0] ONE_LEFT = LEFT_W'(1);

  ld_state_t            state, state_nxt;
  logic [WORD_BITS-1:0] word_sr;
  logic [LEFT_W-1:0]    bits_left;
  logic [WCNT_W-1:0]    word_cnt;
  logic [BCNT_W-1:0]    bit_cnt;
  logic                 in_shift, accept, last_bit, load_go;

  assign in_shift  = (state == ST_SHIFT);
  assign load_go   = (state == ST_IDLE) && start;
  assign setup     = in_shift && (bits_left != '0);
  assign param_out = setup & word_sr[WORD_BITS-1];
  // A new word may land on the same edge the current word's last bit leaves.
  assign in_ready  = in_shift && ((bits_left == '0) || (bits_left == ONE_LEFT))
                     && (word_cnt < WORDS_C);
  assign accept    = in_valid && in_ready;
  assign last_bit  = setup && (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bits_left <= '0;
      word_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_go) begin
        bits_left <= '0;
        word_cnt  <= '0;
        bit_cnt   <= '0;
      end else begin
        if (accept) begin
          bits_left <= WORD_C;
          word_cnt  <= word_cnt + 1'b1;
        end else if (setup) begin
          bits_left <= bits_left - 1'b1;
        end
        if (setup) bit_cnt <= bit_cnt + 1'b1;
        // Padding bits of the final word are dropped, never shifted.
        if (last_bit) bits_left <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      word_sr <= in_data;
    end else if (setup) begin
      word_sr <= word_sr << 1;
    end
  end

`ifdef PARAM_READBACK_EN
  crc8_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (load_go),
    .enable (setup),
    .bit_in (chain_in),
    .crc    (readback_crc)
  );
`else
  logic unused_chain_in;
  assign unused_chain_in = chain_in;
  assign readback_crc    = 8'h00;
`endif

endmodule
